// File: rtl/lcd_arbiter.sv
// Round-robin arbiter that gives four requesters turns on a shared two-line LCD.
// A granted message is latched, handed to the LCD driver, then held on screen for a while.
module lcd_arbiter #(
  parameter int unsigned HOLD_CYCLES    = 50_000_000,
  parameter int unsigned TIMEOUT_CYCLES = 200_000_000
) (
  input  logic         clk,
  input  logic         rst,
  input  logic [3:0]   req,
  input  logic [511:0] req_line1,
  input  logic [511:0] req_line2,
  input  logic         output_done,
  output logic [127:0] first_line,
  output logic [127:0] second_line,
  output logic         output_ready,
  output logic [3:0]   grant,
  output logic [3:0]   done,
  output logic         busy,
  output logic         timeout_err,
  output logic [1:0]   state_o
);

  localparam int HW = $clog2(HOLD_CYCLES + 1);
  localparam int TW = $clog2(TIMEOUT_CYCLES + 1);

  typedef enum logic [1:0] {IDLE = 2'd0, RUN = 2'd1, HOLD = 2'd2} state_t;

  state_t         state_q, state_d;
  logic [127:0]   line1_q, line1_d, line2_q, line2_d;
  logic           ready_q, ready_d, busy_q, busy_d, tmo_err_q, tmo_err_d;
  logic [3:0]     grant_q, grant_d, done_q, done_d;
  logic [1:0]     last_q, last_d;
  logic [HW-1:0]  hold_q, hold_d;
  logic [TW-1:0]  tmo_q, tmo_d;

  logic           win_found;
  logic [1:0]     win_idx, idx;

  // Search starts one past the most recent winner and wraps around.
  always_comb begin
    win_found = 1'b0;
    win_idx   = last_q;
    idx       = '0;
    for (int k = 1; k <= 4; k++) begin
      idx = last_q + 2'(k);
      if (!win_found && req[idx]) begin
        win_found = 1'b1;
        win_idx   = idx;
      end
    end
  end

  always_comb begin
    state_d   = state_q;
    line1_d   = line1_q;
    line2_d   = line2_q;
    ready_d   = ready_q;
    grant_d   = grant_q;
    done_d    = 4'b0000;
    tmo_err_d = tmo_err_q;
    last_d    = last_q;
    hold_d    = hold_q;
    tmo_d     = tmo_q;
    case (state_q)
      IDLE: begin
        if (win_found) begin
          line1_d = req_line1[{win_idx, 7'd0} +: 128];
          line2_d = req_line2[{win_idx, 7'd0} +: 128];
          grant_d = 4'b0001 << win_idx;
          ready_d = 1'b1;
          last_d  = win_idx;
          tmo_d   = '0;
          state_d = RUN;
        end
      end
      RUN: begin
        // Completion wins over a timeout landing on the same edge.
        if (output_done) begin
          ready_d = 1'b0;
          grant_d = 4'b0000;
          done_d  = grant_q;
          hold_d  = HW'(HOLD_CYCLES - 1);
          state_d = HOLD;
        end else if (tmo_q == TW'(TIMEOUT_CYCLES - 1)) begin
          ready_d   = 1'b0;
          grant_d   = 4'b0000;
          tmo_err_d = 1'b1;
          hold_d    = HW'(HOLD_CYCLES - 1);
          state_d   = HOLD;
        end else begin
          tmo_d = tmo_q + 1'b1;
        end
      end
      HOLD: begin
        if (hold_q == '0) state_d = IDLE;
        else              hold_d  = hold_q - 1'b1;
      end
      default: state_d = IDLE;
    endcase
    busy_d = (state_d != IDLE);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q   <= IDLE;
      line1_q   <= '0;
      line2_q   <= '0;
      ready_q   <= 1'b0;
      grant_q   <= 4'b0000;
      done_q    <= 4'b0000;
      busy_q    <= 1'b0;
      tmo_err_q <= 1'b0;
      last_q    <= 2'd3;
      hold_q    <= '0;
      tmo_q     <= '0;
    end else begin
      state_q   <= state_d;
      line1_q   <= line1_d;
      line2_q   <= line2_d;
      ready_q   <= ready_d;
      grant_q   <= grant_d;
      done_q    <= done_d;
      busy_q    <= busy_d;
      tmo_err_q <= tmo_err_d;
      last_q    <= last_d;
      hold_q    <= hold_d;
      tmo_q     <= tmo_d;
    end
  end

  assign first_line   = line1_q;
  assign second_line  = line2_q;
  assign output_ready = ready_q;
  assign grant        = grant_q;
  assign done         = done_q;
  assign busy         = busy_q;
  assign timeout_err  = tmo_err_q;
  assign state_o      = state_q;

endmodule
